// File: rtl/clk_pkg.sv
// Shared encodings for the divided-clock sequencer: command opcodes,
// FSM states and the board clock rate.
package clk_pkg;

    localparam int BOARD_CLK_HZ = 100_000_000;

    typedef enum logic [1:0] {
        OP_STOP  = 2'd0,
        OP_RUN   = 2'd1,
        OP_STEP  = 2'd2,
        OP_BURST = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_BURST     = 2'd2,
        S_STOP_PEND = 2'd3
    } state_t;

endpackage

// File: rtl/clk_prescaler.sv
// Half-period prescaler: toggles clkout every div_lat+1 enabled cycles and
// flags the toggle direction combinationally for the controlling FSM.
module clk_prescaler #(
    parameter int DIV_W = 32
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div_lat,
    output logic             clkout,
    output logic             tick,
    output logic             rise,
    output logic             fall
);

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign wrap = en && (cnt == div_lat);
    assign rise = wrap && !clkout;
    assign fall = wrap && clkout;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            clkout <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tick <= 1'b0;
            // clear only ever coincides with a fall or an idle cycle, so forcing
            // clkout low here never cuts a high phase short
            if (clr) begin
                cnt    <= '0;
                clkout <= 1'b0;
            end else if (wrap) begin
                cnt    <= '0;
                clkout <= ~clkout;
                tick   <= ~clkout;
            end else if (en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkgen_ctrl.sv
// Command sequencer for the divided board clock: RUN / STEP / BURST / STOP
// with glitch-free stopping, done/err strobes and a rising-edge counter.
module clkgen_ctrl #(
    parameter int DIV_W   = 32,
    parameter int BURST_W = 8,
    parameter int PCNT_W  = 16
) (
    input  logic               clkin,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [BURST_W-1:0] cmd_arg,
    input  logic [DIV_W-1:0]   div_half,
    output logic               clkout,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [PCNT_W-1:0]  pulse_cnt
);
    import clk_pkg::*;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div_lat, div_lat_n;
    logic [BURST_W-1:0] burst_left, burst_left_n;
    logic               done_n, err_n;
    logic               accept, rise, fall, pre_en, pre_clr;
    op_t                op;

    assign cmd_ready = (state == S_IDLE) || (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign op        = op_t'(cmd_op);
    assign pre_en    = (state != S_IDLE);
    assign pre_clr   = (state_n == S_IDLE);

    clk_prescaler #(.DIV_W(DIV_W)) u_pre (
        .clkin   (clkin),
        .rst     (rst),
        .en      (pre_en),
        .clr     (pre_clr),
        .div_lat (div_lat),
        .clkout  (clkout),
        .tick    (tick),
        .rise    (rise),
        .fall    (fall)
    );

    always_comb begin
        state_n      = state;
        div_lat_n    = div_lat;
        burst_left_n = burst_left;
        done_n       = 1'b0;
        err_n        = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_RUN: begin
                            div_lat_n = div_half;
                            state_n   = S_RUN;
                        end
                        OP_STEP: begin
                            div_lat_n    = div_half;
                            burst_left_n = BURST_W'(1);
                            state_n      = S_BURST;
                        end
                        OP_BURST: begin
                            if (cmd_arg != '0) begin
                                div_lat_n    = div_half;
                                burst_left_n = cmd_arg;
                                state_n      = S_BURST;
                            end else begin
                                err_n = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (op == OP_STOP) begin
                        // a high phase ending on this very edge is already complete
                        if (rise || (clkout && !fall)) begin
                            state_n = S_STOP_PEND;
                        end else begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (rise)
                    burst_left_n = burst_left - 1'b1;
                if (fall && (burst_left == '0)) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            S_STOP_PEND: begin
                if (fall) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            div_lat    <= '0;
            burst_left <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            pulse_cnt  <= '0;
        end else begin
            state      <= state_n;
            div_lat    <= div_lat_n;
            burst_left <= burst_left_n;
            done       <= done_n;
            err        <= err_n;
            if (rise)
                pulse_cnt <= pulse_cnt + 1'b1;
        end
    end

endmodule

// File: doc/clkgen_ctrl.md
Name: clkgen_ctrl

Overview:
Command-driven sequencer for the board's divided clock. It owns a programmable half-period prescaler and runs it free-running (RUN), for a single output period (STEP) or for N output periods (BURST).
- Always stops glitch-free: clkout is only ever held at 0, and a high phase is never truncated.
- Sits between the control FSM/switch logic and the single-step/slow-clock consumers. It also provides a tick strobe and a rising-edge count for display.

Parameters:
- DIV_W, 32, width of div_half and the internal prescaler counter.
- BURST_W, 8, width of cmd_arg (burst length).
- PCNT_W, 16, width of pulse_cnt.

Ports:
- clkin, input, 1, system clock (100 MHz); all logic on posedge.
- rst, input, 1, asynchronous active-high reset.
- cmd_valid, input, 1, command offered.
- cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready at a posedge.
- cmd_op, input, 2, command: 0 STOP, 1 RUN, 2 STEP, 3 BURST.
- cmd_arg, input, BURST_W, burst length N for BURST; ignored otherwise.
- div_half, input, DIV_W, half-period minus 1 in clkin cycles; sampled into div_lat only on accept of RUN/STEP/BURST.
- clkout, output, 1, divided clock (registered).
- tick, output, 1, one-cycle pulse in the first cycle clkout reads 1 after each rise.
- busy, output, 1, state != IDLE.
- done, output, 1, one-cycle pulse when a STEP/BURST/STOP completes.
- err, output, 1, one-cycle pulse on an illegal accepted command.
- pulse_cnt, output, PCNT_W, clkout rising edges since reset; wraps to 0.

Behaviour:
- Reset (async, any time, including mid-burst):
  - state=IDLE, cnt=0, clkout=0, tick=0, done=0, err=0, pulse_cnt=0, div_lat=0, burst_left=0.
  - Takes effect immediately, with no completion pulse.
- States: IDLE, RUN, BURST, STOP_PEND.
- cmd_ready:
  - 1 in IDLE and RUN.
  - 0 in BURST and STOP_PEND.
- Prescaler:
  - Active in RUN, BURST and STOP_PEND.
  - Each cycle: if cnt==div_lat then cnt<=0 and clkout<=~clkout; else cnt<=cnt+1.
  - Output period = 2*(div_lat+1) cycles. div_half=0 gives clkin/2.
  - First rise occurs div_lat+1 edges after the accepting edge.
- Every rising toggle: tick<=1 and pulse_cnt<=pulse_cnt+1 (wrap).
- IDLE:
  - cnt held at 0, clkout held at 0.
  - RUN: latch div_lat, go to RUN.
  - STEP: latch div_lat, burst_left=1, go to BURST.
  - BURST with cmd_arg!=0: latch div_lat, burst_left=cmd_arg, go to BURST.
  - BURST with cmd_arg==0: err pulse, stay IDLE.
  - STOP: no-op, no done, no err.
- RUN:
  - STOP with clkout==0: go to IDLE, cnt<=0, done pulse next cycle.
  - STOP with clkout==1: go to STOP_PEND.
  - RUN/STEP/BURST: accepted and dropped, err pulse, state and div_lat unchanged.
- BURST:
  - Each rising toggle decrements burst_left.
  - At the falling toggle with burst_left==0: go to IDLE, cnt<=0, done pulse.
  - Exactly N complete high phases are produced.
- STOP_PEND:
  - Counts until the falling toggle, then goes to IDLE, cnt<=0, done pulse.
  - The remaining high phase is full length.
- Registered outputs: done, err and tick are registered and asserted in the cycle after the causing edge decision, i.e. visible immediately after that edge. They are never high two consecutive cycles for one event.
- Simultaneous events: a STOP accepted in the same cycle as a rising toggle resolves as clkout==1, i.e. goes to STOP_PEND.
- div_half changes outside accept have no effect.

Decomposition:
- Shared package (clk_pkg): cmd_op encodings (OP_STOP, OP_RUN, OP_STEP, OP_BURST), state encoding, and the 100 MHz board clock constant.
- One natural sub-module: clk_prescaler. Holds cnt, clkout, tick and rise/fall strobes, with enable, clear and div_lat inputs.
- The FSM, burst counter, handshake, done/err and pulse_cnt stay in clkgen_ctrl.

Test Plan:
- Reset, then BURST with div_half=1, cmd_arg=3 accepted at edge E0 -> clkout rises at E2, E6, E10 and falls at E4, E8, E12. tick after E2, E6, E10. done for the one cycle after E12. busy high E0–E12. pulse_cnt=3. cmd_ready=0 throughout.
- STEP with div_half=0 at E0 -> clkout high only between E1 and E2. done after E2. pulse_cnt+1.
- RUN with div_half=4 -> period 10 cycles. STOP accepted while clkout=1 with 2 high cycles elapsed -> high phase continues to full 5 cycles, then done, state IDLE, clkout=0.
- RUN, then STOP while clkout=0 -> done the next cycle, no further rise. STOP while IDLE -> nothing happens.
- BURST with cmd_arg=0 in IDLE -> err pulse, busy stays 0. STEP issued during RUN -> err pulse, period unchanged.
- Assert rst asynchronously (between edges) mid-BURST after 2 of 5 rises -> clkout, busy, pulse_cnt go to 0 immediately with no done. Then a fresh STEP works normally.
- pulse_cnt wrap: start RUN with div_half=0 -> after 65536 rises pulse_cnt reads 0.
